// File: rtl/w_schedule_stream.sv
// w_schedule_stream: streaming SHA-2 message-schedule generator.
// Loads a 16-word block and emits W[0..ROUNDS-1] one word per ready/valid
// handshake from a 16-word sliding window. WORD_W=32 gives SHA-256 sigma
// functions, WORD_W=64 gives SHA-512.
// Optional feature macro: W_SCHED_VECTOR_EN adds a flat w_vector capture of
// every accepted word plus a w_vector_complete flag.
//
// Handshake: a word transfers on any rising edge where w_valid && w_ready.
// w_valid is registered and never depends on w_ready; while w_valid is high
// and w_ready is low, w_word/w_index/w_last are held unchanged.
module w_schedule_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [16*WORD_W-1:0]   message_block,
    output logic                   busy,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [WORD_W-1:0]      w_word,
    output logic [IDX_W-1:0]       w_index,
    output logic                   w_last,
    output logic                   done,
    output logic [1:0]             dbg_state
`ifdef W_SCHED_VECTOR_EN
    ,
    output logic [ROUNDS*WORD_W-1:0] w_vector,
    output logic                     w_vector_complete
`endif
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("w_schedule_stream: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
        $error("w_schedule_stream: ROUNDS must be in 16..128");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Window element win[i] lives at win_q[15-i], so win[0] (the presented
    // word) sits in the top slot exactly like M[0] in message_block, and a
    // shift is a plain left concatenation.
    state_t                   state_q;
    logic [15:0][WORD_W-1:0]  win_q;
    logic [IDX_W-1:0]         index_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     last_q;
    logic                     done_q;
    logic [WORD_W-1:0]        new_word_d;
    logic                     hs;
    logic                     at_last;
`ifdef W_SCHED_VECTOR_EN
    logic [ROUNDS-1:0][WORD_W-1:0] vec_q;
    logic                          vec_done_q;
    logic [IDX_W-1:0]              vec_sel;
`endif

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
        logic [2*WORD_W-1:0] d;
        d = {x, x} >> n;
        return d[WORD_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    assign hs      = valid_q & w_ready;
    assign at_last = (index_q == IDX_W'(ROUNDS - 1));

    // Next window word: sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0].
    always_comb begin
        new_word_d = sigma1(win_q[1]) + win_q[6] + sigma0(win_q[14]) + win_q[15];
    end

`ifdef W_SCHED_VECTOR_EN
    // Word t lands in slot ROUNDS-1-t so W[0] ends up in the MSBs.
    assign vec_sel = IDX_W'(ROUNDS - 1) - index_q;
`endif

    // Control FSM, window shift and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef W_SCHED_VECTOR_EN
            vec_q      <= '0;
            vec_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        win_q   <= message_block;
                        index_q <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= S_RUN;
`ifdef W_SCHED_VECTOR_EN
                        vec_q      <= '0;
                        vec_done_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (hs) begin
`ifdef W_SCHED_VECTOR_EN
                        vec_q[vec_sel] <= win_q[15];
`endif
                        if (at_last) begin
                            // Window and index are frozen so w_word/w_index
                            // keep showing the final word after w_valid drops.
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`ifdef W_SCHED_VECTOR_EN
                            vec_done_q <= 1'b1;
`endif
                        end else begin
                            win_q   <= {win_q[14:0], new_word_d};
                            index_q <= index_q + IDX_W'(1);
                            last_q  <= (index_q == IDX_W'(ROUNDS - 2));
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign w_valid   = valid_q;
    assign w_word    = win_q[15];
    assign w_index   = index_q;
    assign w_last    = last_q;
    assign done      = done_q;
    assign dbg_state = state_q;
`ifdef W_SCHED_VECTOR_EN
    assign w_vector          = vec_q;
    assign w_vector_complete = vec_done_q;
`endif

endmodule
